// File: rtl/mem_port_arbiter.sv
//==============================================================================
// Module   : mem_port_arbiter
// Purpose  : Shares one single-ported unified memory bus between instruction
//            fetch and the MEM-stage data port. Each access runs a req/ack
//            bus handshake of variable latency. The winning requester gets
//            read data and a one-cycle ready pulse. Combinational stalls hold
//            the fetch stage and the EX/MEM register while an access is
//            pending.
// Options  : MEM_ARB_TIMEOUT_EN -- when defined, a bus access with no ack for
//            MAX_WAIT cycles is abandoned. The access then returns all-ones
//            read data and raises the sticky bus_err flag.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module mem_port_arbiter #(
    parameter int ADDR_BITS = 32,
    parameter int DATA_BITS = 32,
    parameter int MAX_WAIT  = 15
) (
    input  logic                 clk,
    input  logic                 clr_n,
    // fetch port
    input  logic                 if_req,
    input  logic [ADDR_BITS-1:0] if_addr,
    output logic [DATA_BITS-1:0] if_rdata,
    output logic                 if_ready,
    // MEM-stage data port (from EX/MEM register)
    input  logic                 mem_read_m,
    input  logic                 mem_write_m,
    input  logic [ADDR_BITS-1:0] alu_out_m,
    input  logic [DATA_BITS-1:0] write_data_m,
    output logic [DATA_BITS-1:0] d_rdata,
    output logic                 d_ready,
    // pipeline hold
    output logic                 stall_f,
    output logic                 stall_m,
    // unified memory bus
    output logic                 bus_req,
    output logic                 bus_we,
    output logic [ADDR_BITS-1:0] bus_addr,
    output logic [DATA_BITS-1:0] bus_wdata,
    input  logic [DATA_BITS-1:0] bus_rdata,
    input  logic                 bus_ack,
    output logic                 bus_err
);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_BUS_I  = 3'd1,
        ST_BUS_D  = 3'd2,
        ST_DONE_I = 3'd3,
        ST_DONE_D = 3'd4
    } state_t;

    state_t                 r_state;
    state_t                 w_next;

    logic [ADDR_BITS-1:0]   r_bus_addr;
    logic                   r_bus_we;
    logic [DATA_BITS-1:0]   r_bus_wdata;
    logic [DATA_BITS-1:0]   r_if_rdata;
    logic [DATA_BITS-1:0]   r_d_rdata;

    logic                   w_d_pend;
    logic                   w_grant_d;
    logic                   w_grant_i;
    logic                   w_in_bus;
    logic                   w_timeout;
    logic                   w_bus_done;
    logic                   w_bus_req;
    logic                   w_if_ready;
    logic                   w_d_ready;

    // A store with mem_read_m also set is still a store; any data request is pending
    assign w_d_pend  = mem_read_m | mem_write_m;

    // Data has priority: it belongs to the older instruction in the pipeline
    assign w_grant_d = (r_state == ST_IDLE) & w_d_pend;
    assign w_grant_i = (r_state == ST_IDLE) & ~w_d_pend & if_req;

    assign w_in_bus  = (r_state == ST_BUS_I) | (r_state == ST_BUS_D);

`ifdef MEM_ARB_TIMEOUT_EN
    localparam int                 c_CNT_W     = $clog2(MAX_WAIT + 1);
    localparam logic [c_CNT_W-1:0] c_WAIT_LAST = c_CNT_W'(MAX_WAIT - 1);

    logic [c_CNT_W-1:0] r_wait_cnt;
    logic               r_bus_err;

    // Wait counter: counts cycles spent in a bus state, zero everywhere else
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_wait_cnt <= '0;
        end else if (w_in_bus) begin
            r_wait_cnt <= r_wait_cnt + 1'b1;
        end else begin
            r_wait_cnt <= '0;
        end
    end

    // An ack in the final allowed cycle still completes the access normally
    assign w_timeout = w_in_bus & ~bus_ack & (r_wait_cnt == c_WAIT_LAST);

    // Sticky error flag, cleared only by reset
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_bus_err <= 1'b0;
        end else if (w_timeout) begin
            r_bus_err <= 1'b1;
        end
    end

    assign bus_err = r_bus_err;
`else
    assign w_timeout = 1'b0;
    assign bus_err   = 1'b0;
`endif

    // An access leaves its bus state on ack or on abandonment
    assign w_bus_done = bus_ack | w_timeout;

    // State register
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next state and handshake outputs; acks outside a bus state are ignored
    always_comb begin
        w_next     = r_state;
        w_bus_req  = 1'b0;
        w_if_ready = 1'b0;
        w_d_ready  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_d_pend) begin
                    w_next = ST_BUS_D;
                end else if (if_req) begin
                    w_next = ST_BUS_I;
                end
            end
            ST_BUS_I: begin
                w_bus_req = 1'b1;
                if (w_bus_done) begin
                    w_next = ST_DONE_I;
                end
            end
            ST_BUS_D: begin
                w_bus_req = 1'b1;
                if (w_bus_done) begin
                    w_next = ST_DONE_D;
                end
            end
            ST_DONE_I: begin
                w_if_ready = 1'b1;
                w_next     = ST_IDLE;
            end
            ST_DONE_D: begin
                w_d_ready = 1'b1;
                w_next    = ST_IDLE;
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    // Bus command capture at grant; held stable for the whole access
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_bus_addr  <= '0;
            r_bus_we    <= 1'b0;
            r_bus_wdata <= '0;
        end else if (w_grant_d) begin
            r_bus_addr  <= alu_out_m;
            r_bus_we    <= mem_write_m;
            r_bus_wdata <= mem_write_m ? write_data_m : '0;
        end else if (w_grant_i) begin
            r_bus_addr  <= if_addr;
            r_bus_we    <= 1'b0;
            r_bus_wdata <= '0;
        end
    end

    // Instruction word capture; an abandoned fetch returns all ones
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_if_rdata <= '0;
        end else if (r_state == ST_BUS_I) begin
            if (bus_ack) begin
                r_if_rdata <= bus_rdata;
            end else if (w_timeout) begin
                r_if_rdata <= '1;
            end
        end
    end

    // Load data capture; stores never disturb the last load value
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_d_rdata <= '0;
        end else if ((r_state == ST_BUS_D) && !r_bus_we) begin
            if (bus_ack) begin
                r_d_rdata <= bus_rdata;
            end else if (w_timeout) begin
                r_d_rdata <= '1;
            end
        end
    end

    assign bus_req   = w_bus_req;
    assign bus_we    = r_bus_we;
    assign bus_addr  = r_bus_addr;
    assign bus_wdata = r_bus_wdata;
    assign if_rdata  = r_if_rdata;
    assign if_ready  = w_if_ready;
    assign d_rdata   = r_d_rdata;
    assign d_ready   = w_d_ready;

    // Pipeline advances on the edge that ends the ready cycle
    assign stall_m = w_d_pend & ~w_d_ready;
    assign stall_f = if_req & ~w_if_ready;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_arbiter.sv
//==============================================================================
// Module   : tb_mem_port_arbiter
// Purpose  : Self-checking bench for mem_port_arbiter. Expected behaviour is
//            computed from a transaction timeline. Data is served first, each
//            access takes one grant cycle, L bus cycles and one ready cycle.
// Options  : MEM_ARB_TIMEOUT_EN adds the timeout scenario.
// Revision : 1.0 - initial release
//==============================================================================
`default_nettype none

module tb_mem_port_arbiter;

    localparam int AW   = 32;
    localparam int DW   = 32;
    localparam int MAXW = 15;

    logic          clk = 1'b0;
    logic          clr_n;
    logic          if_req;
    logic [AW-1:0] if_addr;
    logic [DW-1:0] if_rdata;
    logic          if_ready;
    logic          mem_read_m;
    logic          mem_write_m;
    logic [AW-1:0] alu_out_m;
    logic [DW-1:0] write_data_m;
    logic [DW-1:0] d_rdata;
    logic          d_ready;
    logic          stall_f;
    logic          stall_m;
    logic          bus_req;
    logic          bus_we;
    logic [AW-1:0] bus_addr;
    logic [DW-1:0] bus_wdata;
    logic [DW-1:0] bus_rdata;
    logic          bus_ack;
    logic          bus_err;

    int            n_checks = 0;
    int            n_pass   = 0;

    // reference state carried between scenarios
    logic [DW-1:0] exp_i_rd;
    logic [DW-1:0] exp_d_rd;
    logic          exp_err;

    always #5 clk = ~clk;

    mem_port_arbiter #(
        .ADDR_BITS (AW),
        .DATA_BITS (DW),
        .MAX_WAIT  (MAXW)
    ) dut (
        .clk          (clk),
        .clr_n        (clr_n),
        .if_req       (if_req),
        .if_addr      (if_addr),
        .if_rdata     (if_rdata),
        .if_ready     (if_ready),
        .mem_read_m   (mem_read_m),
        .mem_write_m  (mem_write_m),
        .alu_out_m    (alu_out_m),
        .write_data_m (write_data_m),
        .d_rdata      (d_rdata),
        .d_ready      (d_ready),
        .stall_f      (stall_f),
        .stall_m      (stall_m),
        .bus_req      (bus_req),
        .bus_we       (bus_we),
        .bus_addr     (bus_addr),
        .bus_wdata    (bus_wdata),
        .bus_rdata    (bus_rdata),
        .bus_ack      (bus_ack),
        .bus_err      (bus_err)
    );

    task automatic inputs_quiet();
        if_req       = 1'b0;
        if_addr      = '0;
        mem_read_m   = 1'b0;
        mem_write_m  = 1'b0;
        alu_out_m    = '0;
        write_data_m = '0;
        bus_ack      = 1'b0;
        bus_rdata    = $urandom;
    endtask

    task automatic test_reset();
        clr_n = 1'b0;
        inputs_quiet();
        repeat (2) @(posedge clk);
        @(negedge clk);
        n_checks++;
        if ({bus_req, bus_we, bus_err, if_ready, d_ready, stall_f, stall_m} !== 7'b0 ||
            bus_addr !== '0 || bus_wdata !== '0 || if_rdata !== '0 || d_rdata !== '0) begin
            $display("FAIL reset_in: ctl=%b addr=%h wdata=%h if_rdata=%h d_rdata=%h, want all zero",
                     {bus_req, bus_we, bus_err, if_ready, d_ready, stall_f, stall_m},
                     bus_addr, bus_wdata, if_rdata, d_rdata);
        end else n_pass++;
        @(posedge clk);
        #1 clr_n = 1'b1;
        exp_i_rd = '0;
        exp_d_rd = '0;
        exp_err  = 1'b0;
        @(negedge clk);
        n_checks++;
        if ({bus_req, if_ready, d_ready, stall_f, stall_m, bus_err} !== 6'b0) begin
            $display("FAIL reset_release: ctl=%b, want 000000",
                     {bus_req, if_ready, d_ready, stall_f, stall_m, bus_err});
        end else n_pass++;
        @(posedge clk);
        #1;
    endtask

    // Timeline model: data access (if any) granted at cycle 0 with bus cycles
    // 1..lat_d and ready at lat_d+1. Fetch is granted in the IDLE cycle after
    // that (or at 0 alone), then lat_i bus cycles and one ready cycle.
    task automatic run_scenario(input string nm, input bit do_i, input bit do_r,
                                input bit do_w, input int lat_d, input int lat_i,
                                input logic [AW-1:0] ia, input logic [AW-1:0] da,
                                input logic [DW-1:0] wd, input logic [DW-1:0] rd_i,
                                input logic [DW-1:0] rd_d);
        bit  dp;
        int  d_rdy;
        int  i_rdy;
        int  i_start;
        int  last;
        bit  in_d;
        bit  in_i;
        logic [5:0] exp_ctl;
        logic [5:0] act_ctl;
        dp      = do_r | do_w;
        d_rdy   = dp ? lat_d + 1 : -1;
        i_start = dp ? lat_d + 2 : 0;
        i_rdy   = do_i ? i_start + lat_i + 1 : -1;
        last    = ((d_rdy > i_rdy) ? d_rdy : i_rdy) + 1;
        if_addr      = ia;
        alu_out_m    = da;
        write_data_m = wd;
        for (int c = 0; c <= last; c++) begin
            mem_read_m  = do_r && (c <= d_rdy);
            mem_write_m = do_w && (c <= d_rdy);
            if_req      = do_i && (c <= i_rdy);
            in_d = dp && (c >= 1) && (c <= lat_d);
            in_i = do_i && (c > i_start) && (c <= i_start + lat_i);
            if (dp && c == lat_d) begin
                bus_ack = 1'b1; bus_rdata = rd_d;
            end else if (do_i && c == i_start + lat_i) begin
                bus_ack = 1'b1; bus_rdata = rd_i;
            end else begin
                bus_ack = 1'b0; bus_rdata = $urandom;
            end
            @(negedge clk);
            if (c == d_rdy && !do_w) exp_d_rd = rd_d;
            if (c == i_rdy) exp_i_rd = rd_i;
            exp_ctl = {in_d | in_i, 1'(c == i_rdy), 1'(c == d_rdy),
                       1'(do_i && c < i_rdy), 1'(dp && c < d_rdy), exp_err};
            act_ctl = {bus_req, if_ready, d_ready, stall_f, stall_m, bus_err};
            n_checks++;
            if (act_ctl !== exp_ctl) begin
                $display("FAIL %s ctl c=%0d: got req/ifr/dr/sf/sm/err=%b want %b",
                         nm, c, act_ctl, exp_ctl);
            end else n_pass++;
            if (in_d) begin
                n_checks++;
                if ({bus_addr, bus_we, bus_wdata} !== {da, do_w, (do_w ? wd : '0)}) begin
                    $display("FAIL %s dbus c=%0d: got addr=%h we=%b wdata=%h want %h %b %h",
                             nm, c, bus_addr, bus_we, bus_wdata, da, do_w, (do_w ? wd : '0));
                end else n_pass++;
            end
            if (in_i) begin
                n_checks++;
                if ({bus_addr, bus_we} !== {ia, 1'b0}) begin
                    $display("FAIL %s ibus c=%0d: got addr=%h we=%b want %h 0",
                             nm, c, bus_addr, bus_we, ia);
                end else n_pass++;
            end
            n_checks++;
            if ({if_rdata, d_rdata} !== {exp_i_rd, exp_d_rd}) begin
                $display("FAIL %s rdata c=%0d: got if=%h d=%h want if=%h d=%h",
                         nm, c, if_rdata, d_rdata, exp_i_rd, exp_d_rd);
            end else n_pass++;
            @(posedge clk);
            #1;
        end
        inputs_quiet();
    endtask

    task automatic test_directed();
        run_scenario("fetch_basic", 1'b1, 1'b0, 1'b0, 1, 2, 32'h0000_0040,
                     32'h0, 32'h0, 32'h8C22_0004, 32'h0);
        run_scenario("both_load_first", 1'b1, 1'b1, 1'b0, 2, 1, 32'h0000_0044,
                     32'h0000_1000, 32'h0, 32'h0123_4567, 32'hCAFE_F00D);
        run_scenario("store_fast", 1'b0, 1'b0, 1'b1, 1, 1, 32'h0,
                     32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 32'h5555_AAAA);
        run_scenario("rw_is_write", 1'b1, 1'b1, 1'b1, 3, 2, 32'h0000_0048,
                     32'h0000_0020, 32'h1357_9BDF, 32'h2468_ACE0, 32'h7777_7777);
    endtask

    task automatic test_random();
        bit di;
        bit dr;
        bit dw;
        for (int n = 0; n < 40; n++) begin
            di = 1'($urandom_range(0, 1));
            dr = 1'($urandom_range(0, 1));
            dw = 1'($urandom_range(0, 1));
            if (!di && !dr && !dw) di = 1'b1;
            run_scenario("random", di, dr, dw, int'($urandom_range(1, 4)),
                         int'($urandom_range(1, 4)), $urandom, $urandom, $urandom,
                         $urandom, $urandom);
        end
    endtask

    // Load withdrawn during its bus phase still completes and pulses ready
    task automatic test_flush();
        logic [DW-1:0] x;
        logic [5:0]    exp_ctl;
        x         = $urandom;
        alu_out_m = $urandom;
        for (int c = 0; c <= 4; c++) begin
            mem_read_m = (c == 0);
            bus_ack    = (c == 2);
            bus_rdata  = (c == 2) ? x : $urandom;
            @(negedge clk);
            if (c == 3) exp_d_rd = x;
            exp_ctl = {1'(c == 1 || c == 2), 1'b0, 1'(c == 3), 1'b0, 1'(c == 0), exp_err};
            n_checks++;
            if ({bus_req, if_ready, d_ready, stall_f, stall_m, bus_err} !== exp_ctl ||
                d_rdata !== exp_d_rd) begin
                $display("FAIL flush c=%0d: ctl=%b d_rdata=%h want %b %h", c,
                         {bus_req, if_ready, d_ready, stall_f, stall_m, bus_err},
                         d_rdata, exp_ctl, exp_d_rd);
            end else n_pass++;
            @(posedge clk);
            #1;
        end
        inputs_quiet();
    endtask

    task automatic test_spurious_ack();
        for (int c = 0; c <= 3; c++) begin
            bus_ack   = (c < 3);
            bus_rdata = $urandom;
            @(negedge clk);
            n_checks++;
            if ({bus_req, if_ready, d_ready, stall_f, stall_m, bus_err} !== {5'b0, exp_err} ||
                {if_rdata, d_rdata} !== {exp_i_rd, exp_d_rd}) begin
                $display("FAIL spurious_ack c=%0d: ctl=%b if=%h d=%h want %b %h %h", c,
                         {bus_req, if_ready, d_ready, stall_f, stall_m, bus_err},
                         if_rdata, d_rdata, {5'b0, exp_err}, exp_i_rd, exp_d_rd);
            end else n_pass++;
            @(posedge clk);
            #1;
        end
        inputs_quiet();
    endtask

`ifdef MEM_ARB_TIMEOUT_EN
    task automatic test_timeout();
        logic [5:0] exp_ctl;
        alu_out_m = $urandom;
        for (int c = 0; c <= MAXW + 2; c++) begin
            mem_read_m = (c <= MAXW + 1);
            bus_ack    = 1'b0;
            bus_rdata  = $urandom;
            @(negedge clk);
            if (c == MAXW + 1) begin
                exp_err  = 1'b1;
                exp_d_rd = '1;
            end
            exp_ctl = {1'(c >= 1 && c <= MAXW), 1'b0, 1'(c == MAXW + 1), 1'b0,
                       1'(c < MAXW + 1), exp_err};
            n_checks++;
            if ({bus_req, if_ready, d_ready, stall_f, stall_m, bus_err} !== exp_ctl ||
                d_rdata !== exp_d_rd) begin
                $display("FAIL timeout c=%0d: ctl=%b d_rdata=%h want %b %h", c,
                         {bus_req, if_ready, d_ready, stall_f, stall_m, bus_err},
                         d_rdata, exp_ctl, exp_d_rd);
            end else n_pass++;
            @(posedge clk);
            #1;
        end
        inputs_quiet();
        run_scenario("after_timeout", 1'b1, 1'b1, 1'b0, 2, 3, $urandom, $urandom,
                     $urandom, $urandom, $urandom);
    endtask
`endif

    // Reset asserted mid-load; an ack after release must be ignored
    task automatic test_reset_mid();
        mem_read_m = 1'b1;
        alu_out_m  = $urandom | 32'h1;
        @(posedge clk);
        #1 mem_read_m = 1'b0;
        @(negedge clk);
        n_checks++;
        if (bus_req !== 1'b1) begin
            $display("FAIL reset_mid_busy: bus_req=%b want 1", bus_req);
        end else n_pass++;
        #1 clr_n = 1'b0;
        #1;
        n_checks++;
        if ({bus_req, bus_we, bus_err, if_ready, d_ready, stall_f, stall_m} !== 7'b0 ||
            bus_addr !== '0 || bus_wdata !== '0 || if_rdata !== '0 || d_rdata !== '0) begin
            $display("FAIL reset_mid_async: ctl=%b addr=%h if=%h d=%h, want all zero",
                     {bus_req, bus_we, bus_err, if_ready, d_ready, stall_f, stall_m},
                     bus_addr, if_rdata, d_rdata);
        end else n_pass++;
        exp_i_rd = '0;
        exp_d_rd = '0;
        exp_err  = 1'b0;
        @(posedge clk);
        #1 clr_n = 1'b1;
        for (int c = 0; c <= 2; c++) begin
            bus_ack   = (c == 0);
            bus_rdata = $urandom;
            @(negedge clk);
            n_checks++;
            if ({bus_req, if_ready, d_ready, stall_f, stall_m, bus_err} !== 6'b0 ||
                {if_rdata, d_rdata} !== {exp_i_rd, exp_d_rd}) begin
                $display("FAIL reset_mid_ack c=%0d: ctl=%b if=%h d=%h want 000000 0 0", c,
                         {bus_req, if_ready, d_ready, stall_f, stall_m, bus_err},
                         if_rdata, d_rdata);
            end else n_pass++;
            @(posedge clk);
            #1;
        end
        inputs_quiet();
        run_scenario("after_reset", 1'b1, 1'b0, 1'b1, 1, 1, $urandom, $urandom,
                     $urandom, $urandom, $urandom);
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_flush();
        test_spurious_ack();
`ifdef MEM_ARB_TIMEOUT_EN
        test_timeout();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
